// File: rtl/uart_tx_scheduler_if.sv
// Bus bundle for uart_tx_scheduler: requester handshake plus transmitter
// control. The scheduler connects through the slave modport; whatever drives
// the requests and models the transmitter uses the master modport.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic                    enable_i;
  logic [NUM_REQ-1:0]      req_i;
  logic [32*NUM_REQ-1:0]   req_data_i;
  logic                    tx_done_i;
  logic [NUM_REQ-1:0]      ack_o;
  logic                    err_o;
  logic                    busy_o;
  logic [2:0]              grant_idx_o;
  logic                    start_tx_o;
  logic [31:0]             tx_data_o;

  modport slave (
    input  enable_i, req_i, req_data_i, tx_done_i,
    output ack_o, err_o, busy_o, grant_idx_o, start_tx_o, tx_data_o
  );

  modport master (
    output enable_i, req_i, req_data_i, tx_done_i,
    input  ack_o, err_o, busy_o, grant_idx_o, start_tx_o, tx_data_o
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter in front of a single UART transmitter.
// IDLE -> START (one-cycle start pulse) -> WAIT_DONE -> ACK (one-cycle ack) -> IDLE.
// Optional watchdog: define UART_TX_TIMEOUT_EN to bound WAIT_DONE to
// TIMEOUT_CYCLES cycles; a timed-out transfer still acks, with err_o set.
// All outputs come from registers or from the state register.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic             clk,
  input logic             reset_n,
  uart_tx_scheduler_if.slave bus
);

  // Elaboration-time sanity check on the configuration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, ACK} state_e;

  state_e             state_q;
  logic [2:0]         grant_q;     // current/last granted requester
  logic [2:0]         last_q;      // round-robin pointer, updated only in ACK
  logic [NUM_REQ-1:0] ack_q;
  logic               start_q;
  logic [31:0]        data_q;

`ifdef UART_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  logic [2:0] win_idx;
  logic       win_vld;
  int         cand;

  // Round-robin pick: scan from last_q+1 upward (with wrap); the lowest
  // offset with a request wins, so iterate far-to-near and let later hits override.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = int'(last_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (bus.req_i[cand]) begin
        win_idx = 3'(cand);
        win_vld = 1'b1;
      end
    end
  end

  // Scheduler FSM with registered start/ack/err pulses and latched grant data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 3'(NUM_REQ - 1);
      ack_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
`ifdef UART_TX_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
`ifdef UART_TX_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.enable_i && win_vld) begin
            grant_q <= win_idx;
            data_q  <= bus.req_data_i[32*win_idx +: 32];
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          // tx_done_i is deliberately not looked at here.
          state_q <= WAIT_DONE;
`ifdef UART_TX_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WAIT_DONE: begin
          if (bus.tx_done_i) begin
            ack_q   <= NUM_REQ'(1) << grant_q;
            state_q <= ACK;
          end
`ifdef UART_TX_TIMEOUT_EN
          // cnt_q counts completed WAIT_DONE cycles; the limit cycle is the last one.
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            ack_q   <= NUM_REQ'(1) << grant_q;
            err_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
`endif
        end
        ACK: begin
          last_q  <= grant_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack_o       = ack_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.grant_idx_o = grant_q;
  assign bus.start_tx_o  = start_q;
  assign bus.tx_data_o   = data_q;
`ifdef UART_TX_TIMEOUT_EN
  assign bus.err_o       = err_q;
`else
  assign bus.err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized transfers
// checked against a round-robin/latency reference model.
module tb_uart_tx_scheduler;
  localparam int N = 4;

  logic clk;
  logic reset_n;
  int   passed;
  int   total;
  int   last_g;
  logic [31:0] dat [N];

  uart_tx_scheduler_if #(.NUM_REQ(N)) bus ();

  uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference arbitration: first requester at or after last+1, wrapping around.
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int i = 1; i <= N; i++)
      if (req[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic drive_data;
    bus.req_data_i = {dat[3], dat[2], dat[1], dat[0]};
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    bus.enable_i = 1'b0; bus.req_i = '0; bus.tx_done_i = 1'b0;
    tick; tick;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ack", bus.ack_o, 0);
    chk("rst_start", bus.start_tx_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_grant", bus.grant_idx_o, 0);
    chk("rst_data", bus.tx_data_o, 0);
    reset_n = 1'b1;
    last_g  = N - 1;
  endtask

  // One full transfer from IDLE; leaves the block in IDLE with req_i unchanged
  // unless drop is set (requests/enable withdrawn right after the grant).
  task automatic xfer(input logic [N-1:0] req, input int dly, input bit early, input bit drop);
    int w;
    logic [31:0] d;
    logic [N-1:0] exp_ack;
    drive_data;
    bus.req_i = req; bus.enable_i = 1'b1; bus.tx_done_i = early;
    w = rr_pick(req, last_g);
    d = dat[w];
    exp_ack = N'(1) << w;
    tick;
    chk("start_pulse", bus.start_tx_o, 1);
    chk("grant_idx", bus.grant_idx_o, w);
    chk("tx_data", bus.tx_data_o, d);
    chk("busy_start", bus.busy_o, 1);
    if (drop) begin
      bus.req_i = '0; bus.enable_i = 1'b0;
      for (int k = 0; k < N; k++) dat[k] = $urandom;
      drive_data;
    end
    tick;
    chk("start_one_cycle", bus.start_tx_o, 0);
    chk("no_ack_first_wait", bus.ack_o, 0);
    for (int k = 0; k < dly; k++) begin
      bus.tx_done_i = 1'b0;
      tick;
      chk("no_ack_waiting", bus.ack_o, 0);
    end
    bus.tx_done_i = 1'b1;
    tick;
    chk("ack", bus.ack_o, exp_ack);
    chk("err_clear", bus.err_o, 0);
    chk("data_stable", bus.tx_data_o, d);
    bus.tx_done_i = 1'b0;
    tick;
    chk("ack_one_cycle", bus.ack_o, 0);
    chk("idle_after_ack", bus.busy_o, 0);
    last_g = w;
  endtask

  initial begin
    passed = 0; total = 0;
    for (int k = 0; k < N; k++) dat[k] = $urandom;
    drive_data;
    apply_reset;

    // Single request from requester 2.
    dat[2] = 32'hA5;
    xfer(4'b0100, 3, 1'b0, 1'b0);
    chk("single_grant2", bus.grant_idx_o, 2);
    bus.req_i = '0;

    // Round robin with all requests held: 0,1,2,3,0.
    apply_reset;
    for (int k = 0; k < N; k++) dat[k] = 32'h1000_0000 + k;
    for (int t = 0; t < 5; t++) begin
      xfer(4'b1111, t, 1'b0, 1'b0);
      chk("rr_order", bus.grant_idx_o, t % N);
    end
    bus.req_i = '0;

    // Enable low blocks grants.
    bus.enable_i = 1'b0; bus.req_i = 4'b0001;
    for (int t = 0; t < 20; t++) begin
      tick;
      chk("disabled_no_start", bus.start_tx_o, 0);
    end
    xfer(4'b0001, 2, 1'b0, 1'b0);
    bus.req_i = '0;

    // tx_done high before and during START is ignored there.
    xfer(4'b0010, 0, 1'b1, 1'b0);
    bus.req_i = '0;

    // Reset in WAIT_DONE: no ack, pointer back to requester-0-first.
    xfer(4'b0001, 1, 1'b0, 1'b0);
    bus.req_i = 4'b0100; bus.enable_i = 1'b1;
    tick; tick;
    chk("pre_reset_busy", bus.busy_o, 1);
    reset_n = 1'b0;
    bus.req_i = '0;
    #1;
    chk("mid_reset_busy", bus.busy_o, 0);
    chk("mid_reset_ack", bus.ack_o, 0);
    tick;
    chk("mid_reset_ack_held", bus.ack_o, 0);
    reset_n = 1'b1;
    last_g = N - 1;
    xfer(4'b0011, 1, 1'b0, 1'b0);
    chk("post_reset_grant0", bus.grant_idx_o, 0);
    bus.req_i = '0;

`ifdef UART_TX_TIMEOUT_EN
    // Watchdog: tx_done stuck low, ack+err after 16 WAIT_DONE cycles.
    bus.req_i = 4'b1000; bus.enable_i = 1'b1; bus.tx_done_i = 1'b0;
    tick;
    chk("to_start", bus.start_tx_o, 1);
    bus.req_i = '0;
    for (int t = 0; t < 16; t++) begin
      tick;
      chk("to_no_ack", bus.ack_o, 0);
    end
    tick;
    chk("to_ack", bus.ack_o, 4'b1000);
    chk("to_err", bus.err_o, 1);
    tick;
    chk("to_idle", bus.busy_o, 0);
    last_g = 3;
`endif

    // Randomized transfers against the reference model.
    for (int t = 0; t < 40; t++) begin
      int dly;
      for (int k = 0; k < N; k++) dat[k] = $urandom;
      dly = $urandom_range(0, 4);
      xfer(N'($urandom_range(1, 15)), dly, (dly == 0) && ($urandom_range(0, 1) == 1),
           $urandom_range(0, 2) == 0);
    end
    bus.req_i = '0;
    tick;
    chk("final_idle", bus.busy_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
